bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 Parameter DATA_WIDTH, default 8, bus data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, watchdog limit (1..65535); used only with BUS_ARB_TIMEOUT_EN.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_REQ  per-requester transaction request.
REQ-008 req_we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-009 req_addr  input  NUM_REQ x ADDR_WIDTH  per-requester address.
REQ-010 req_wdata  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-011 req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-012 rsp_valid  output  1  completion strobe.
REQ-013 rsp_id  output  $clog2(NUM_REQ)  index of the completing requester.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-015 rsp_err  output  1  completion aborted by timeout.
REQ-016 bus_valid, bus_we, bus_addr, bus_wdata  outputs  1/1/ADDR_WIDTH/DATA_WIDTH  master-side bus request.
REQ-017 bus_ready  input  1  follower accept; bus_rdata  input  DATA_WIDTH  follower read data, valid when bus_ready=1.

Function
REQ-018 The FSM SHALL have two states: IDLE and BUSY.
REQ-019 In IDLE with any req_valid=1, the block SHALL select a winner by round-robin, starting the search at the index held in pointer ptr, and enter BUSY on the next edge.
REQ-020 req_ready[winner] SHALL be 1 combinationally in that IDLE cycle only; all other bits SHALL be 0, and req_ready SHALL be all-zero in BUSY.
REQ-021 On grant, the block SHALL register req_we/req_addr/req_wdata of the winner, and SHALL set ptr = (winner+1) mod NUM_REQ.
REQ-022 In BUSY, bus_valid SHALL be 1 and bus_we/bus_addr/bus_wdata SHALL hold the registered values, stable until bus_ready=1.
REQ-023 On a BUSY cycle with bus_ready=1, the FSM SHALL return to IDLE, and the next cycle SHALL carry rsp_valid=1 for one cycle, with rsp_id=winner and rsp_rdata=bus_rdata (read) or 0 (write).
REQ-024 A grant SHALL be issued at most every 2 cycles; grant-to-bus_valid latency SHALL be 1 cycle.
REQ-025 A requester that drops req_valid before its grant SHALL NOT be granted, and ptr SHALL be unchanged.
REQ-026 bus_ready while in IDLE SHALL be ignored.
REQ-027 NUM_REQ not a power of 2 SHALL wrap ptr correctly, from NUM_REQ-1 to 0.

Reset
REQ-028 While rst=0: state=IDLE, ptr=0, and every output including req_ready, bus_valid, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_id, rsp_rdata and rsp_err SHALL be 0, asynchronously.
REQ-029 A reset during BUSY SHALL drop bus_valid immediately, with no rsp_valid for the aborted transaction.

Configuration
REQ-030 With BUS_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without bus_ready.
REQ-031 When the counter reaches TIMEOUT_CYCLES, the block SHALL abort to IDLE and, next cycle, SHALL drive rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-032 With BUS_ARB_TIMEOUT_EN defined, bus_ready SHALL take priority if it arrives on the same cycle the limit is reached.
REQ-033 Without BUS_ARB_TIMEOUT_EN, the counter SHALL be absent, rsp_err SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Verification
REQ-034 Single write: req_valid[2]=1, we=1, addr=0x10, wdata=0xA5, bus_ready=1 on first BUSY cycle -> req_ready=0b0100, bus_valid 1 cycle later with addr 0x10/wdata 0xA5, rsp_valid with rsp_id=2, rsp_rdata=0.
REQ-035 Round-robin: all 4 req_valid held high -> grants 0,1,2,3,0 on every second cycle; no requester is skipped.
REQ-036 Read with stall: req 1 read at 0x44, bus_ready low 3 cycles then high with bus_rdata=0x3C -> bus_addr stable for 4 BUSY cycles, then rsp_valid, rsp_id=1, rsp_rdata=0x3C.
REQ-037 Reset mid-BUSY: rst=0 on second BUSY cycle -> bus_valid=0 in the same cycle, no rsp_valid, and after release ptr=0 so req 0 wins against req 3.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=8): bus_ready held 0 -> bus_valid drops after 8 BUSY cycles, then rsp_valid=1, rsp_err=1.
REQ-039 Withdrawn request: req_valid[3] pulsed 1 cycle while BUSY -> req 3 not granted and ptr unchanged.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin N:1 bus arbiter; grant is combinational in IDLE, bus request follows 1 cycle later, response 1 cycle after bus_ready.
// One transaction in flight: req_ready stays low while BUSY. Optional watchdog abort under `define BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic                             bus_valid,
   output logic                             bus_we,
   output logic [ADDR_WIDTH-1:0]            bus_addr,
   output logic [DATA_WIDTH-1:0]            bus_wdata,
   input  logic                             bus_ready,
   input  logic [DATA_WIDTH-1:0]            bus_rdata
);

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [IDW-1:0]          win_idx;
   logic                    found;
   logic                    grant, done, abort, tmo_hit;
   logic [IDW-1:0]          id_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    rsp_valid_q;
   logic [IDW-1:0]          rsp_id_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;

   // First active requester at or after ptr, wrapping at NUM_REQ (not at 2**IDW).
   always_comb begin : win_search
      int             idx;
      logic [IDW-1:0] cand;
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = IDW'(idx);
         if (!found && req_valid[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      ptr_d   = ptr_q;
      grant   = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant   = 1'b1;
               state_d = BUSY;
               ptr_d   = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         BUSY: begin
            if (bus_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (tmo_hit) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   // Gated by rst so the strobe is low throughout reset, not just after the next edge.
   always_comb begin : ready_dec
      req_ready = '0;
      if (grant && rst) req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= done | abort;
         if (grant) begin
            id_q    <= win_idx;
            we_q    <= req_we[win_idx];
            addr_q  <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
         end
         if (done) begin
            rsp_id_q    <= id_q;
            rsp_rdata_q <= we_q ? '0 : bus_rdata;
         end else if (abort) begin
            rsp_id_q    <= id_q;
            rsp_rdata_q <= '0;
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   logic [15:0] cnt_q;
   logic        rsp_err_q;

   // cnt_q counts stalled BUSY cycles; the limit is hit on the stall that would make it TIMEOUT_CYCLES.
   assign tmo_hit = (state_q == BUSY) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (grant) cnt_q <= '0;
         else if (state_q == BUSY && !bus_ready) cnt_q <= cnt_q + 16'd1;
         if (done || abort) rsp_err_q <= abort;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;

   // TIMEOUT_CYCLES has no effect without the watchdog; this only keeps it referenced.
   if (TIMEOUT_CYCLES < 1) begin : g_tmo_param_unused
   end
`endif

   assign bus_valid = (state_q == BUSY);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_bus_rr_arbiter;
   localparam int N = 4, AW = 32, DW = 8, TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_we, req_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic            rsp_valid, rsp_err, bus_valid, bus_we, bus_ready;
   logic [1:0]      rsp_id;
   logic [DW-1:0]   rsp_rdata, bus_wdata, bus_rdata;
   logic [AW-1:0]   bus_addr;

   bus_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata));

   // Three-requester instance: pointer must wrap from 2 back to 0.
   logic            rst3 = 1'b0;
   logic [2:0]      ready3;
   logic            rsp_valid3, rsp_err3, bus_valid3, bus_we3;
   logic [1:0]      rsp_id3;
   logic [DW-1:0]   rsp_rdata3, bus_wdata3;
   logic [AW-1:0]   bus_addr3;

   bus_rr_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) u_dut3 (
      .clk(clk), .rst(rst3), .req_valid(3'b111), .req_we(3'b000), .req_addr({3*AW{1'b0}}),
      .req_wdata({3*DW{1'b0}}), .req_ready(ready3), .rsp_valid(rsp_valid3), .rsp_id(rsp_id3),
      .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .bus_valid(bus_valid3), .bus_we(bus_we3),
      .bus_addr(bus_addr3), .bus_wdata(bus_wdata3), .bus_ready(1'b1), .bus_rdata(8'h00));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction-level model: who owns the bus, what it asked for, what response is owed.
   bit            m_busy = 0, m_pend = 0, m_perr = 0, m_we = 0;
   int            m_ptr = 0, m_owner = 0, m_pid = 0, m_cnt = 0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_prdata;

   int cyc = 0;
   int last_grant_cyc = -10;
   int g_idx[$];
   int g_cyc[$];
   int g3[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : cmp
      logic [N-1:0] exp_ready;
      int           w;
      if (!rst) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_bus_valid", bus_valid, 0);
         chk("rst_bus_addr", bus_addr, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_rsp_err", rsp_err, 0);
         m_busy = 0; m_ptr = 0; m_pend = 0; m_cnt = 0;
      end else begin
         w = -1;
         exp_ready = '0;
         if (!m_busy)
            for (int k = 0; k < N; k++)
               if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         if (w >= 0) exp_ready[w] = 1'b1;
         chk("req_ready", req_ready, exp_ready);
         chk("bus_valid", bus_valid, m_busy);
         if (m_busy) begin
            chk("bus_we", bus_we, m_we);
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_wdata", bus_wdata, m_wdata);
         end
         chk("rsp_valid", rsp_valid, m_pend);
         if (m_pend) begin
            chk("rsp_id", rsp_id, m_pid);
            chk("rsp_rdata", rsp_rdata, m_prdata);
            chk("rsp_err", rsp_err, m_perr);
         end
         for (int k = 0; k < N; k++)
            if (req_ready[k]) begin g_idx.push_back(k); g_cyc.push_back(cyc); end
         if (req_ready != 0) begin
            chk("grant_gap", (cyc - last_grant_cyc) >= 2, 1);
            last_grant_cyc = cyc;
         end
         m_pend = 0;
         if (w >= 0) begin
            m_busy = 1; m_owner = w; m_we = req_we[w];
            m_addr = req_addr[w*AW +: AW]; m_wdata = req_wdata[w*DW +: DW];
            m_ptr = (w + 1) % N; m_cnt = 0;
         end else if (m_busy) begin
            if (bus_ready) begin
               m_busy = 0; m_pend = 1; m_pid = m_owner; m_perr = 0;
               m_prdata = m_we ? '0 : bus_rdata;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else begin
               m_cnt++;
               if (m_cnt == TMO) begin
                  m_busy = 0; m_pend = 1; m_pid = m_owner; m_perr = 1; m_prdata = '0;
               end
            end
`endif
         end
      end
   end

   always @(negedge clk)
      if (rst3)
         for (int k = 0; k < 3; k++) if (ready3[k]) g3.push_back(k);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int rr_exp[5];
      int w3_exp[5];
      int nb;
      rr_exp = '{0, 1, 2, 3, 0};
      w3_exp = '{0, 1, 2, 0, 1};
      req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0;
      bus_ready = 1'b1; bus_rdata = '0;
      repeat (2) tick();
      chk("rst_gate_ready", req_ready, 0);
      req_valid = '0; bus_ready = 1'b0;
      rst = 1'b1; rst3 = 1'b1;
      tick();

      // Single write from requester 2
      set_req(2, 1, 32'h10, 8'hA5); req_valid = 4'b0100; bus_ready = 1'b1;
      @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
      tick(); req_valid = '0;
      @(negedge clk);
      chk("t1_bus_valid", bus_valid, 1); chk("t1_bus_we", bus_we, 1);
      chk("t1_bus_addr", bus_addr, 32'h10); chk("t1_bus_wdata", bus_wdata, 8'hA5);
      tick();
      @(negedge clk);
      chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rsp_id", rsp_id, 2); chk("t1_rsp_rdata", rsp_rdata, 0);
      tick(); bus_ready = 1'b0;

      // Round-robin from a fresh pointer with every requester active
      rst = 1'b0; tick(); rst = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 0, 32'(i * 4), 8'(i));
      bus_rdata = 8'h5A; bus_ready = 1'b1; req_valid = 4'hF;
      g_idx.delete(); g_cyc.delete();
      repeat (10) tick();
      req_valid = '0; tick(); tick();
      for (int k = 0; k < 5; k++) begin
         if (k < g_idx.size()) begin
            chk($sformatf("t2_grant%0d", k), g_idx[k], rr_exp[k]);
            chk($sformatf("t2_spacing%0d", k), g_cyc[k] - g_cyc[0], 2 * k);
         end else chk($sformatf("t2_missing%0d", k), 0, 1);
      end
      bus_ready = 1'b0;

      // Read from requester 1 with three stall cycles
      set_req(1, 0, 32'h44, 8'h00); req_valid = 4'b0010;
      @(negedge clk); chk("t3_ready", req_ready, 4'b0010);
      tick(); req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t3_stall_valid%0d", k), bus_valid, 1);
         chk($sformatf("t3_stall_addr%0d", k), bus_addr, 32'h44);
         tick();
      end
      bus_ready = 1'b1; bus_rdata = 8'h3C;
      @(negedge clk); chk("t3_addr_last", bus_addr, 32'h44); chk("t3_valid_last", bus_valid, 1);
      tick(); bus_ready = 1'b0; bus_rdata = 8'h00;
      @(negedge clk);
      chk("t3_rsp_valid", rsp_valid, 1); chk("t3_rsp_id", rsp_id, 1); chk("t3_rsp_rdata", rsp_rdata, 8'h3C);
      tick();

      // Reset on the second BUSY cycle; pointer was 2 before it
      set_req(1, 0, 32'h80, 8'h00); req_valid = 4'b0010;
      tick(); req_valid = '0;
      tick();
      rst = 1'b0; #1;
      chk("t4_bus_valid_drop", bus_valid, 0); chk("t4_rsp_valid_drop", rsp_valid, 0);
      tick(); rst = 1'b1;
      set_req(0, 0, 32'hA0, 8'h00); set_req(3, 0, 32'hA3, 8'h00); req_valid = 4'b1001;
      @(negedge clk); chk("t4_winner", req_ready, 4'b0001); chk("t4_no_rsp", rsp_valid, 0);
      tick(); req_valid = '0; bus_ready = 1'b1;
      tick(); tick(); bus_ready = 1'b0;

      // Requester 3 pulses while requester 0 holds the bus
      set_req(0, 1, 32'hB0, 8'h77); req_valid = 4'b0001;
      tick(); req_valid = '0;
      tick(); req_valid = 4'b1000;
      @(negedge clk); chk("t5_ready_busy", req_ready, 0);
      tick(); req_valid = '0;
      tick(); bus_ready = 1'b1;
      tick(); bus_ready = 1'b0;
      req_valid = 4'b1010;
      @(negedge clk); chk("t5_ptr_kept", req_ready, 4'b0010);
      tick(); req_valid = '0; bus_ready = 1'b1;
      tick(); tick(); bus_ready = 1'b0;

      // Stalled slave: watchdog abort or indefinite wait
      set_req(2, 1, 32'h20, 8'h11); req_valid = 4'b0100;
      tick(); req_valid = '0;
      nb = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!bus_valid) break;
         nb++;
         tick();
      end
`ifdef BUS_ARB_TIMEOUT_EN
      chk("t6_busy_cycles", nb, TMO);
      chk("t6_rsp_valid", rsp_valid, 1); chk("t6_rsp_err", rsp_err, 1); chk("t6_rsp_rdata", rsp_rdata, 0);
      tick();
`else
      chk("t6_wait_forever", nb, 20);
      bus_ready = 1'b1; tick(); bus_ready = 1'b0;
      @(negedge clk); chk("t6_rsp_err", rsp_err, 0); chk("t6_rsp_valid", rsp_valid, 1);
      tick();
`endif

      // Random traffic, including withdrawn requests, idle bus_ready and stray resets
      repeat (600) begin
         req_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
         bus_ready = ($urandom_range(0, 3) != 0);
         bus_rdata = 8'($urandom);
         rst = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst = 1'b1; req_valid = '0; bus_ready = 1'b1;
      repeat (3) tick();

      for (int k = 0; k < 5; k++) begin
         if (k < g3.size()) chk($sformatf("wrap3_grant%0d", k), g3[k], w3_exp[k]);
         else chk($sformatf("wrap3_missing%0d", k), 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
